// File: rtl/tpi_handshake_if.sv
// rtl/tpi_handshake_if.sv - host, port A and handshake signal bundle for tpi_handshake
interface tpi_handshake_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       mode;
    logic [7:0] pa_in;
    logic [7:0] pa_out;
    logic       pa_oe;
    logic       dav_out;
    logic       ack_in;
    logic       dav_in;
    logic       ack_out;
    logic       busy;
    logic       timeout_err;
    logic       err_clr;

    // Design side
    modport slave (
        input  tx_data, tx_valid, rx_ack, mode, pa_in, ack_in, dav_in, err_clr,
        output tx_ready, rx_data, rx_valid, pa_out, pa_oe, dav_out, ack_out,
        output busy, timeout_err
    );

    // Host / peer side
    modport master (
        output tx_data, tx_valid, rx_ack, mode, pa_in, ack_in, dav_in, err_clr,
        input  tx_ready, rx_data, rx_valid, pa_out, pa_oe, dav_out, ack_out,
        input  busy, timeout_err
    );
endinterface

// File: rtl/tpi_handshake.sv
// rtl/tpi_handshake.sv - parallel port DAV/ACK handshake engine with transmit FIFO
module tpi_handshake #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic            i_clk,
    input  logic            i_rst,
    tpi_handshake_if.slave  bus
);
    localparam int         AW       = $clog2(FIFO_DEPTH);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, TX_SETUP, TX_WAIT_HI, TX_WAIT_LO, RX_WAIT_LO, ERROR
    } state_t;

    state_t        r_state;
    logic          r_ack_s1, r_ack_s2, r_dav_s1, r_dav_s2;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic [7:0]    r_tmo_cnt;
    logic [7:0]    r_pa_out, r_rx_data;
    logic          r_pa_oe, r_dav_out, r_ack_out, r_rx_valid, r_timeout_err;

    logic          w_tx_ready, w_push, w_pop, w_tmo_hit;

    assign w_tx_ready = (r_count != (AW+1)'(FIFO_DEPTH));
    assign w_push     = bus.tx_valid && w_tx_ready;
    // The head byte leaves the FIFO only once the peer has acknowledged it.
    assign w_pop      = (r_state == TX_WAIT_HI) && r_ack_s2;
    assign w_tmo_hit  = (r_tmo_cnt == TMO_LAST);

    assign bus.tx_ready    = w_tx_ready;
    assign bus.rx_data     = r_rx_data;
    assign bus.rx_valid    = r_rx_valid;
    assign bus.pa_out      = r_pa_out;
    assign bus.pa_oe       = r_pa_oe;
    assign bus.dav_out     = r_dav_out;
    assign bus.ack_out     = r_ack_out;
    assign bus.busy        = (r_state != IDLE);
    assign bus.timeout_err = r_timeout_err;

    // Two-flop synchronizers for the asynchronous peer strobes
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ack_s1 <= 1'b0;
            r_ack_s2 <= 1'b0;
            r_dav_s1 <= 1'b0;
            r_dav_s2 <= 1'b0;
        end else begin
            r_ack_s1 <= bus.ack_in;
            r_ack_s2 <= r_ack_s1;
            r_dav_s1 <= bus.dav_in;
            r_dav_s2 <= r_dav_s1;
        end
    end

    // FIFO storage write; contents are don't-care while the FIFO is empty
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.tx_data;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Handshake FSM with registered strobes, receive holding register and timeout counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_tmo_cnt     <= '0;
            r_pa_out      <= 8'h00;
            r_pa_oe       <= 1'b0;
            r_dav_out     <= 1'b0;
            r_ack_out     <= 1'b0;
            r_rx_data     <= 8'h00;
            r_rx_valid    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            // Host consumption; a capture below in the same cycle takes priority
            if (bus.rx_ack) r_rx_valid <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_tmo_cnt <= '0;
                    if (!bus.mode) begin
                        if (r_count != '0) begin
                            r_pa_out <= r_mem[r_rd_ptr];
                            r_pa_oe  <= 1'b1;
                            r_state  <= TX_SETUP;
                        end
                    end else if (r_dav_s2 && !r_rx_valid) begin
                        r_rx_data  <= bus.pa_in;
                        r_rx_valid <= 1'b1;
                        r_ack_out  <= 1'b1;
                        r_state    <= RX_WAIT_LO;
                    end
                end
                TX_SETUP: begin
                    r_tmo_cnt <= '0;
                    r_dav_out <= 1'b1;
                    r_state   <= TX_WAIT_HI;
                end
                TX_WAIT_HI: begin
                    if (r_ack_s2) begin
                        r_tmo_cnt <= '0;
                        r_dav_out <= 1'b0;
                        r_state   <= TX_WAIT_LO;
                    end else if (w_tmo_hit) begin
                        r_tmo_cnt     <= '0;
                        r_timeout_err <= 1'b1;
                        r_dav_out     <= 1'b0;
                        r_ack_out     <= 1'b0;
                        r_pa_oe       <= 1'b0;
                        r_state       <= ERROR;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                TX_WAIT_LO: begin
                    if (!r_ack_s2) begin
                        r_tmo_cnt <= '0;
                        r_pa_oe   <= 1'b0;
                        r_state   <= IDLE;
                    end else if (w_tmo_hit) begin
                        r_tmo_cnt     <= '0;
                        r_timeout_err <= 1'b1;
                        r_dav_out     <= 1'b0;
                        r_ack_out     <= 1'b0;
                        r_pa_oe       <= 1'b0;
                        r_state       <= ERROR;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                RX_WAIT_LO: begin
                    if (!r_dav_s2) begin
                        r_tmo_cnt <= '0;
                        r_ack_out <= 1'b0;
                        r_state   <= IDLE;
                    end else if (w_tmo_hit) begin
                        r_tmo_cnt     <= '0;
                        r_timeout_err <= 1'b1;
                        r_dav_out     <= 1'b0;
                        r_ack_out     <= 1'b0;
                        r_pa_oe       <= 1'b0;
                        r_state       <= ERROR;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                ERROR: begin
                    r_tmo_cnt <= '0;
                    r_dav_out <= 1'b0;
                    r_ack_out <= 1'b0;
                    r_pa_oe   <= 1'b0;
                    if (bus.err_clr) begin
                        r_timeout_err <= 1'b0;
                        r_state       <= IDLE;
                    end
                end
                default: begin
                    r_tmo_cnt <= '0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tpi_handshake.sv
// tb/tb_tpi_handshake.sv - scoreboard testbench for tpi_handshake
module tb_tpi_handshake;
    localparam int TMO = 24;
    localparam int S_DAV = 0, S_ACK = 1, S_OE = 2, S_RXV = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [7:0] exp_tx [$];
    logic [7:0] exp_rx [$];

    tpi_handshake_if bus ();

    tpi_handshake #(.FIFO_DEPTH(4), .TIMEOUT(TMO)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic sigval(input int sel);
        case (sel)
            S_DAV:   return bus.dav_out;
            S_ACK:   return bus.ack_out;
            S_OE:    return bus.pa_oe;
            default: return bus.rx_valid;
        endcase
    endfunction

    task automatic wait_lvl(input int sel, input logic val, input int lim, input string nm);
        int n = 0;
        while (sigval(sel) !== val && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(sigval(sel)), 32'(val));
    endtask

    // One push attempt; expectation is queued only when the FIFO accepts it
    task automatic push(input logic [7:0] d, input logic exp_rdy);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        chk("tx_ready_at_push", 32'(bus.tx_ready), 32'(exp_rdy));
        if (exp_rdy) exp_tx.push_back(d);
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    // Peer side of a send: ack 3 cycles after dav rises, release 3 cycles after it falls
    task automatic peer_tx();
        wait_lvl(S_DAV, 1'b1, 40, "dav_rise");
        repeat (3) @(negedge clk);
        bus.ack_in = 1'b1;
        wait_lvl(S_DAV, 1'b0, 20, "dav_fall");
        repeat (3) @(negedge clk);
        bus.ack_in = 1'b0;
        wait_lvl(S_OE, 1'b0, 20, "oe_release");
    endtask

    // Monitor: every new DAV or new rx_valid is a DUT output checked against the queues
    initial begin
        logic prev_dav = 1'b0;
        logic prev_rxv = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.dav_out && !prev_dav) begin
                if (exp_tx.size() == 0) begin
                    total++; bad++;
                    $display("FAIL tx_unexpected actual=%h required=none", bus.pa_out);
                end else begin
                    chk("tx_byte", 32'(bus.pa_out), 32'(exp_tx.pop_front()));
                    chk("tx_oe", 32'(bus.pa_oe), 32'd1);
                end
            end
            if (bus.rx_valid && !prev_rxv) begin
                if (exp_rx.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rx_unexpected actual=%h required=none", bus.rx_data);
                end else begin
                    chk("rx_byte", 32'(bus.rx_data), 32'(exp_rx.pop_front()));
                    chk("rx_oe", 32'(bus.pa_oe), 32'd0);
                end
            end
            prev_dav = bus.dav_out;
            prev_rxv = bus.rx_valid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tx_data = 8'h00; bus.tx_valid = 1'b0; bus.rx_ack = 1'b0;
        bus.mode = 1'b0; bus.pa_in = 8'h00; bus.ack_in = 1'b0;
        bus.dav_in = 1'b0; bus.err_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_pa_oe", 32'(bus.pa_oe), 32'd0);
        chk("rst_pa_out", 32'(bus.pa_out), 32'h00);
        chk("rst_dav_out", 32'(bus.dav_out), 32'd0);
        chk("rst_ack_out", 32'(bus.ack_out), 32'd0);
        chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("rst_rx_data", 32'(bus.rx_data), 32'h00);
        chk("rst_timeout_err", 32'(bus.timeout_err), 32'd0);

        // Single byte send
        push(8'hA5, 1'b1);
        peer_tx();
        chk("send_pa_out_hold", 32'(bus.pa_out), 32'hA5);
        chk("send_tx_ready", 32'(bus.tx_ready), 32'd1);
        repeat (5) @(negedge clk);
        chk("send_fifo_empty_dav", 32'(bus.dav_out), 32'd0);
        chk("send_idle", 32'(bus.busy), 32'd0);

        // Fill FIFO: four accepted, fifth refused, then sent in order
        push(8'h01, 1'b1);
        push(8'h02, 1'b1);
        push(8'h03, 1'b1);
        push(8'h04, 1'b1);
        push(8'h05, 1'b0);
        for (int i = 0; i < 4; i++) peer_tx();
        repeat (5) @(negedge clk);
        chk("fill_drained_busy", 32'(bus.busy), 32'd0);

        // Timeout in TX_WAIT_HI, byte retained and resent after err_clr
        push(8'h77, 1'b1);
        wait_lvl(S_DAV, 1'b1, 10, "tmo_dav_rise");
        repeat (TMO - 1) @(negedge clk);
        chk("tmo_not_yet", 32'(bus.timeout_err), 32'd0);
        @(negedge clk);
        chk("tmo_err_set", 32'(bus.timeout_err), 32'd1);
        chk("tmo_dav_low", 32'(bus.dav_out), 32'd0);
        chk("tmo_oe_low", 32'(bus.pa_oe), 32'd0);
        repeat (5) @(negedge clk);
        chk("tmo_sticky", 32'(bus.timeout_err), 32'd1);
        chk("tmo_busy", 32'(bus.busy), 32'd1);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        chk("tmo_cleared", 32'(bus.timeout_err), 32'd0);
        exp_tx.push_back(8'h77);
        peer_tx();

        // Receive with backpressure
        bus.mode  = 1'b1;
        bus.pa_in = 8'h3C;
        exp_rx.push_back(8'h3C);
        bus.dav_in = 1'b1;
        wait_lvl(S_ACK, 1'b1, 10, "rx_ack_rise");
        chk("rx_valid_set", 32'(bus.rx_valid), 32'd1);
        bus.dav_in = 1'b0;
        wait_lvl(S_ACK, 1'b0, 10, "rx_ack_fall");
        bus.pa_in  = 8'h5A;
        bus.dav_in = 1'b1;
        repeat (10) @(negedge clk);
        chk("rx_bp_no_ack", 32'(bus.ack_out), 32'd0);
        chk("rx_bp_data_hold", 32'(bus.rx_data), 32'h3C);
        chk("rx_bp_idle", 32'(bus.busy), 32'd0);
        exp_rx.push_back(8'h5A);
        bus.rx_ack = 1'b1;
        @(negedge clk);
        bus.rx_ack = 1'b0;
        wait_lvl(S_ACK, 1'b1, 10, "rx2_ack_rise");
        bus.dav_in = 1'b0;
        wait_lvl(S_ACK, 1'b0, 10, "rx2_ack_fall");
        bus.rx_ack = 1'b1;
        @(negedge clk);
        bus.rx_ack = 1'b0;
        chk("rx_consumed", 32'(bus.rx_valid), 32'd0);

        // Reset during TX_WAIT_HI with three bytes queued
        bus.mode = 1'b0;
        @(negedge clk);
        push(8'h11, 1'b1);
        push(8'h22, 1'b1);
        push(8'h33, 1'b1);
        wait_lvl(S_DAV, 1'b1, 10, "rst_dav_rise");
        rst = 1'b1;
        @(negedge clk);
        exp_tx.delete();
        chk("abort_dav", 32'(bus.dav_out), 32'd0);
        chk("abort_oe", 32'(bus.pa_oe), 32'd0);
        chk("abort_tx_ready", 32'(bus.tx_ready), 32'd1);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_pa_out", 32'(bus.pa_out), 32'h00);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_fifo_empty", 32'(bus.dav_out), 32'd0);
        chk("abort_stays_idle", 32'(bus.busy), 32'd0);

        chk("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
        chk("rx_queue_drained", 32'(exp_rx.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
